// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned MUL / MULHU / DIVU / REMU unit.
// One shift-add (multiply) or restoring shift-subtract (divide) iteration
// per clock, WIDTH iterations per operation. The upstream pipeline is
// frozen through `stall` while an operation is being accepted or is running;
// `done` pulses for one cycle with `result` valid, and `result` then holds
// until the next operation completes.
//
// Handshake: `start` is a request that is only honoured in IDLE when
// `flush` is low; there is no ready output -- the requester must keep the
// instruction (and start) in place while `stall` is high. A request made
// outside IDLE is dropped, not queued.

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Operation encodings: op[1] selects divide, op[0] selects the
    // "upper" half (high product / remainder) of the final {acc, q} pair.
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH:0]      r_acc;
    logic [WIDTH-1:0]    r_q;
    logic [WIDTH-1:0]    r_opnd_b;
    logic [1:0]          r_op;
    logic [WIDTH-1:0]    r_result;

    logic                w_accept;
    logic                w_last;

    // Multiply iteration signals.
    logic [WIDTH:0]      w_mul_sum;
    logic [WIDTH:0]      w_mul_acc;
    logic [WIDTH-1:0]    w_mul_q;

    // Divide iteration signals. The difference carries one extra bit so
    // its MSB is the borrow of the trial subtraction.
    logic [WIDTH:0]      w_div_shift;
    logic [WIDTH+1:0]    w_div_diff;
    logic                w_div_ok;
    logic [WIDTH:0]      w_div_acc;
    logic [WIDTH-1:0]    w_div_q;

    // Selected iteration outcome and the value it would publish.
    logic [WIDTH:0]      w_iter_acc;
    logic [WIDTH-1:0]    w_iter_q;
    logic [WIDTH-1:0]    w_iter_result;

    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_last   = (r_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush always returns the unit to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // One shift-add step: conditionally add the multiplicand, then shift
    // the {acc, q} pair right so the next multiplier bit lands in q[0].
    always_comb begin
        w_mul_sum = r_acc;
        if (r_q[0]) begin
            w_mul_sum = r_acc + {1'b0, r_opnd_b};
        end
        w_mul_acc = {1'b0, w_mul_sum[WIDTH:1]};
        w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end

    // One restoring-division step: bring the next dividend bit into the
    // partial remainder and keep the subtraction only if it did not borrow.
    // A zero divisor never borrows, which yields all-ones quotient and the
    // dividend as remainder without any special casing.
    always_comb begin
        w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd_b};
        w_div_ok    = !w_div_diff[WIDTH+1];
        w_div_acc   = w_div_ok ? w_div_diff[WIDTH:0] : w_div_shift;
        w_div_q     = {r_q[WIDTH-2:0], w_div_ok};
    end

    // Choose the active algorithm and the half of the result to publish.
    always_comb begin
        w_iter_acc = w_mul_acc;
        w_iter_q   = w_mul_q;
        if (r_op[1]) begin
            w_iter_acc = w_div_acc;
            w_iter_q   = w_div_q;
        end
        case (r_op)
            OP_MUL:   w_iter_result = w_iter_q;
            OP_MULHU: w_iter_result = w_iter_acc[WIDTH-1:0];
            OP_DIVU:  w_iter_result = w_iter_q;
            OP_REMU:  w_iter_result = w_iter_acc[WIDTH-1:0];
            default:  w_iter_result = w_iter_q;
        endcase
    end

    // Datapath registers: capture on accept, iterate in RUN, publish the
    // result on the final iteration. A flush freezes everything in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_opnd_b <= '0;
            r_op     <= 2'b00;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= op;
                        r_opnd_b <= b;
                        r_q      <= a;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_acc <= w_iter_acc;
                        r_q   <= w_iter_q;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_result <= w_iter_result;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall     = w_accept || (r_state == S_RUN);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE) && !flush;
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule
